ftdi_tx: RTL

FT232H synchronous-245 FIFO write path: buffers bytes from the fabric in a small FIFO and drives `wr_n`/`data_out` toward the FTDI chip on the 60 MHz FTDI clock, honouring `txe_n` backpressure with exact per-edge acceptance accounting. It sits beside the FTDI read path on the shared 8-bit bus. Bus turnaround is arbitrated outside this block through `hold`.

---
 rtl/ftdi_pkg.sv | 12 +
 rtl/ftdi_tx_fifo.sv | 48 ++++
 rtl/ftdi_tx.sv | 89 ++++++++
 3 files changed

// File: rtl/ftdi_pkg.sv
// Shared FT232H sync-245 definitions used by the read path, write path and bus arbiter.
package ftdi_pkg;

  localparam int unsigned FTDI_DATA_W = 8;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_RX   = 2'd1,
    BUS_TX   = 2'd2
  } ftdi_bus_e;

endpackage

// File: rtl/ftdi_tx_fifo.sv
// First-word-fall-through byte FIFO for the FTDI write path; extra-MSB pointers give full/empty.
module ftdi_tx_fifo
  import ftdi_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                   clk_60,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [FTDI_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [FTDI_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [FIFO_AW:0]       level
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  logic [FTDI_DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0]       wr_ptr;
  logic [FIFO_AW:0]       rd_ptr;
  logic                   do_wr;
  logic                   do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk_60) begin
    if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
    end
  end

endmodule

// File: rtl/ftdi_tx.sv
// FT232H sync-245 write path: FWFT FIFO plus registered wr_n/data_out stage honouring txe_n and hold.
// Define FTDI_TX_SIWU_EN to add the flush input and SIWU send-immediate strobe.
module ftdi_tx
  import ftdi_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                   clk_60,
  input  logic                   rst_n,
  input  logic [FTDI_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic                   hold,
  input  logic                   txe_n,
  output logic                   wr_n,
  output logic [FTDI_DATA_W-1:0] data_out,
  output logic                   data_oe,
  output logic [FIFO_AW:0]       fifo_level
`ifdef FTDI_TX_SIWU_EN
  ,
  input  logic                   flush,
  output logic                   siwu_n
`endif
);

  logic                   out_valid;
  logic                   out_valid_next;
  logic                   accepted;
  logic                   load;
  logic                   pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [FTDI_DATA_W-1:0] fifo_head;

  ftdi_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_60  (clk_60),
    .rst_n   (rst_n),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign tx_ready = ~fifo_full;

  // wr_n low with txe_n high is not an acceptance: the byte stays in the output register.
  assign accepted       = ~wr_n & ~txe_n;
  assign load           = accepted | ~out_valid;
  assign pop            = load & ~fifo_empty;
  assign out_valid_next = load ? ~fifo_empty : out_valid;

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wr_n      <= 1'b1;
      data_out  <= '0;
      data_oe   <= 1'b0;
    end else begin
      if (pop) data_out <= fifo_head;
      out_valid <= out_valid_next;
      wr_n      <= ~out_valid_next | txe_n | hold;
      data_oe   <= out_valid_next & ~hold;
    end
  end

`ifdef FTDI_TX_SIWU_EN
  logic flush_pend;
  logic siwu_fire;

  // A flush arriving on the firing edge is absorbed into the pulse being issued.
  assign siwu_fire = flush_pend & fifo_empty & ~out_valid;

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
      siwu_n     <= 1'b1;
    end else begin
      siwu_n     <= ~siwu_fire;
      flush_pend <= siwu_fire ? 1'b0 : (flush_pend | flush);
    end
  end
`endif

endmodule
